// File: rtl/pwl_stim_gen.sv
// Piecewise-linear stimulus generator.
// Segments (start value, slope, length) are queued through a valid/ready
// FIFO and played out one fixed-point sample per clock. A fractional
// accumulator carries the ramp, and the output saturates instead of wrapping.
module pwl_stim_gen #(
   parameter int WIDTH       = 16,
   parameter int SLOPE_WIDTH = 16,
   parameter int SLOPE_FRAC  = 8,
   parameter int DUR_WIDTH   = 16,
   parameter int DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   seg_valid,
   output logic                   seg_ready,
   input  logic [WIDTH-1:0]       seg_value,
   input  logic [SLOPE_WIDTH-1:0] seg_slope,
   input  logic [DUR_WIDTH-1:0]   seg_cycles,
   output logic [WIDTH-1:0]       out_value,
   output logic                   out_valid,
   output logic                   busy,
   output logic                   underrun,
   output logic                   sat
);

   localparam int ACC_W = WIDTH + SLOPE_FRAC + 2;
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   // Segment FIFO storage and pointers
   logic [WIDTH-1:0]       valueMem_q  [DEPTH];
   logic [SLOPE_WIDTH-1:0] slopeMem_q  [DEPTH];
   logic [DUR_WIDTH-1:0]   cyclesMem_q [DEPTH];
   logic [PTR_W-1:0]       rdPtr_q, wrPtr_q;
   logic [PTR_W:0]         count_q, count_d;

   // Active segment and output state
   state_t                   state_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [SLOPE_WIDTH-1:0]   slope_q;
   logic [DUR_WIDTH-1:0]     remaining_q;
   logic [WIDTH-1:0]         outValue_q;
   logic                     outValid_q;
   logic                     underrun_q;
   logic                     sat_q;

   // Pop / load decision signals
   logic                   push;
   logic                   needSeg;
   logic                   doLoad;
   logic                   endEmpty;
   logic [1:0]             popCnt;
   logic [PTR_W-1:0]       nextIdx;
   logic [PTR_W-1:0]       loadIdx;
   logic [WIDTH-1:0]       loadValue;
   logic [SLOPE_WIDTH-1:0] loadSlope;
   logic [DUR_WIDTH-1:0]   loadCycles;

   // Ramp arithmetic signals
   logic signed [ACC_W-1:0] slopeExt;
   logic signed [ACC_W-1:0] accSum;
   logic signed [ACC_W-1:0] accShift;
   logic signed [ACC_W-1:0] outMaxExt;
   logic signed [ACC_W-1:0] outMinExt;
   logic signed [ACC_W-1:0] accMax;
   logic signed [ACC_W-1:0] accMin;
   logic signed [ACC_W-1:0] loadAcc;
   logic signed [ACC_W-1:0] stepAcc;
   logic [WIDTH-1:0]        stepOut;
   logic                    stepClip;

   assign seg_ready = rst_n && (count_q != (PTR_W+1)'(DEPTH));
   assign push      = seg_valid && seg_ready;
   assign nextIdx   = rdPtr_q + PTR_W'(1);
   assign count_d   = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(popCnt);

   assign out_value = outValue_q;
   assign out_valid = outValid_q;
   assign underrun  = underrun_q;
   assign sat       = sat_q;
   assign busy      = (state_q == RUN) || (count_q != '0);

   // Decide how many FIFO entries leave this edge and whether a segment loads;
   // at most one zero-length head is discarded before looking at the next one
   always_comb begin
      needSeg  = (state_q == IDLE) || (remaining_q == '0);
      popCnt   = 2'd0;
      doLoad   = 1'b0;
      endEmpty = 1'b0;
      loadIdx  = rdPtr_q;
      if (needSeg) begin
         if (count_q != '0) begin
            if (cyclesMem_q[rdPtr_q] != '0) begin
               doLoad = 1'b1;
               popCnt = 2'd1;
            end else begin
               popCnt = 2'd1;
               if (count_q >= (PTR_W+1)'(2)) begin
                  if (cyclesMem_q[nextIdx] != '0) begin
                     doLoad  = 1'b1;
                     popCnt  = 2'd2;
                     loadIdx = nextIdx;
                  end
               end else begin
                  endEmpty = 1'b1;
               end
            end
         end else if (state_q == RUN) begin
            endEmpty = 1'b1;
         end
      end
   end

   assign loadValue  = valueMem_q[loadIdx];
   assign loadSlope  = slopeMem_q[loadIdx];
   assign loadCycles = cyclesMem_q[loadIdx];

   // Next accumulator and sample for one ramp step, clamped to the output range
   always_comb begin
      slopeExt  = {{(ACC_W-SLOPE_WIDTH){slope_q[SLOPE_WIDTH-1]}}, slope_q};
      accSum    = acc_q + slopeExt;
      accShift  = accSum >>> SLOPE_FRAC;
      outMaxExt = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
      outMinExt = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      accMax    = {outMaxExt[ACC_W-SLOPE_FRAC-1:0], {SLOPE_FRAC{1'b0}}};
      accMin    = {outMinExt[ACC_W-SLOPE_FRAC-1:0], {SLOPE_FRAC{1'b0}}};
      loadAcc   = {{(ACC_W-WIDTH-SLOPE_FRAC){loadValue[WIDTH-1]}}, loadValue,
                   {SLOPE_FRAC{1'b0}}};
      stepAcc   = accSum;
      stepOut   = accShift[WIDTH-1:0];
      stepClip  = 1'b0;
      if (accShift > outMaxExt) begin
         stepAcc  = accMax;
         stepOut  = outMaxExt[WIDTH-1:0];
         stepClip = 1'b1;
      end else if (accShift < outMinExt) begin
         stepAcc  = accMin;
         stepOut  = outMinExt[WIDTH-1:0];
         stepClip = 1'b1;
      end
   end

   // FIFO payload capture; contents need no reset because the count gates them
   always_ff @(posedge clk) begin
      if (push) begin
         valueMem_q[wrPtr_q]  <= seg_value;
         slopeMem_q[wrPtr_q]  <= seg_slope;
         cyclesMem_q[wrPtr_q] <= seg_cycles;
      end
   end

   // FIFO pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         rdPtr_q <= rdPtr_q + PTR_W'(popCnt);
         count_q <= count_d;
      end
   end

   // IDLE/RUN sequencer: load segments back to back, step the ramp, hold in IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         slope_q     <= '0;
         remaining_q <= '0;
         outValue_q  <= '0;
         outValid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         if (doLoad) begin
            state_q     <= RUN;
            acc_q       <= loadAcc;
            slope_q     <= loadSlope;
            remaining_q <= loadCycles - DUR_WIDTH'(1);
            outValue_q  <= loadValue;
            outValid_q  <= 1'b1;
         end else if ((state_q == RUN) && (remaining_q != '0)) begin
            acc_q       <= stepAcc;
            outValue_q  <= stepOut;
            remaining_q <= remaining_q - DUR_WIDTH'(1);
            if (stepClip) begin
               sat_q <= 1'b1;
            end
         end else if (state_q == RUN) begin
            state_q <= IDLE;
         end
         if (endEmpty) begin
            underrun_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwl_stim_gen.sv
// Testbench for pwl_stim_gen: directed scenarios plus random segment traffic,
// all checked every cycle against a closed-form segment model.
module tb_pwl_stim_gen;

   localparam int WIDTH = 16;
   localparam int SLOPE_WIDTH = 16;
   localparam int SLOPE_FRAC = 8;
   localparam int DUR_WIDTH = 16;
   localparam int DEPTH = 4;
   localparam longint OUT_MAX = 32767;
   localparam longint OUT_MIN = -32768;

   logic clk;
   logic rst_n;
   logic seg_valid;
   logic seg_ready;
   logic [WIDTH-1:0] seg_value;
   logic [SLOPE_WIDTH-1:0] seg_slope;
   logic [DUR_WIDTH-1:0] seg_cycles;
   logic [WIDTH-1:0] out_value;
   logic out_valid;
   logic busy;
   logic underrun;
   logic sat;

   int vectorCount = 0;
   int missCount = 0;
   int acceptCount = 0;

   // Reference model state: queued segments and the segment being played
   longint qV[$];
   longint qS[$];
   longint qN[$];
   bit mActive;
   longint mV, mS, mN, mK;
   longint mOut;
   bit mValid, mUnder, mSat;

   pwl_stim_gen #(
      .WIDTH(WIDTH), .SLOPE_WIDTH(SLOPE_WIDTH), .SLOPE_FRAC(SLOPE_FRAC),
      .DUR_WIDTH(DUR_WIDTH), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready),
      .seg_value(seg_value), .seg_slope(seg_slope), .seg_cycles(seg_cycles),
      .out_value(out_value), .out_valid(out_valid), .busy(busy),
      .underrun(underrun), .sat(sat)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Sample k of a segment: v + k*s/2^FRAC, floored, then clamped
   function automatic longint sampleAt(input longint v, input longint s, input longint k,
                                       output bit clipped);
      longint raw;
      raw = ((v * (64'sd1 <<< SLOPE_FRAC)) + k * s) >>> SLOPE_FRAC;
      clipped = 1'b0;
      if (raw > OUT_MAX) begin
         raw = OUT_MAX;
         clipped = 1'b1;
      end else if (raw < OUT_MIN) begin
         raw = OUT_MIN;
         clipped = 1'b1;
      end
      return raw;
   endfunction

   task automatic modelLoad(input longint v, input longint s, input longint n);
      mActive = 1'b1;
      mV = v;
      mS = s;
      mN = n;
      mK = 0;
      mOut = v;
      mValid = 1'b1;
   endtask

   task automatic modelReset();
      qV.delete();
      qS.delete();
      qN.delete();
      mActive = 1'b0;
      mV = 0; mS = 0; mN = 0; mK = 0;
      mOut = 0;
      mValid = 1'b0;
      mUnder = 1'b0;
      mSat = 1'b0;
   endtask

   // One clock edge of the reference model, using the inputs the bench drove
   task automatic modelEdge();
      bit accept;
      bit loaded;
      bit clipped;
      if (!rst_n) begin
         modelReset();
         return;
      end
      accept = seg_valid && (qN.size() < DEPTH);
      if (mActive && (mK < mN - 1)) begin
         mK++;
         mOut = sampleAt(mV, mS, mK, clipped);
         if (clipped) mSat = 1'b1;
      end else begin
         loaded = 1'b0;
         if (qN.size() > 0) begin
            if (qN[0] != 0) begin
               modelLoad(qV[0], qS[0], qN[0]);
               loaded = 1'b1;
               void'(qV.pop_front()); void'(qS.pop_front()); void'(qN.pop_front());
            end else begin
               void'(qV.pop_front()); void'(qS.pop_front()); void'(qN.pop_front());
               if (qN.size() > 0) begin
                  if (qN[0] != 0) begin
                     modelLoad(qV[0], qS[0], qN[0]);
                     loaded = 1'b1;
                     void'(qV.pop_front()); void'(qS.pop_front()); void'(qN.pop_front());
                  end
               end else begin
                  mUnder = 1'b1;
               end
            end
         end else if (mActive) begin
            mUnder = 1'b1;
         end
         if (!loaded) mActive = 1'b0;
      end
      if (accept) begin
         acceptCount++;
         qV.push_back(longint'($signed(seg_value)));
         qS.push_back(longint'($signed(seg_slope)));
         qN.push_back(longint'(seg_cycles));
      end
   endtask

   task automatic compareAll();
      checkOutput("out_value", longint'($signed(out_value)), mOut);
      checkOutput("out_valid", longint'(out_valid), longint'(mValid));
      checkOutput("busy", longint'(busy), longint'(mActive || (qN.size() > 0)));
      checkOutput("underrun", longint'(underrun), longint'(mUnder));
      checkOutput("sat", longint'(sat), longint'(mSat));
      checkOutput("seg_ready", longint'(seg_ready), longint'(rst_n && (qN.size() < DEPTH)));
   endtask

   // Drive one cycle of inputs, clock it, advance the model, check all outputs
   task automatic applyStimulus(input bit rstn, input bit valid, input int v, input int s,
                                input int n);
      rst_n = rstn;
      seg_valid = valid;
      seg_value = WIDTH'(v);
      seg_slope = SLOPE_WIDTH'(s);
      seg_cycles = DUR_WIDTH'(n);
      @(posedge clk);
      modelEdge();
      #1;
      compareAll();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 0, 0);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      seg_valid = 1'b0;
      seg_value = '0;
      seg_slope = '0;
      seg_cycles = '0;
      modelReset();

      // Reset state
      doReset();
      checkOutput("rst_out_valid", longint'(out_valid), 0);
      checkOutput("rst_ready_low", longint'(seg_ready), 0);

      // Single ramp with integer slope
      applyStimulus(1'b1, 1'b1, 100, 256, 4);
      checkOutput("ramp_latency", longint'(out_valid), 0);
      for (int i = 0; i < 4; i++) begin
         idleCycles(1);
         checkOutput("ramp_sample", longint'($signed(out_value)), 100 + i);
      end
      checkOutput("ramp_busy_last", longint'(busy), 1);
      checkOutput("ramp_under_last", longint'(underrun), 0);
      idleCycles(1);
      checkOutput("ramp_hold", longint'($signed(out_value)), 103);
      checkOutput("ramp_busy_end", longint'(busy), 0);
      checkOutput("ramp_underrun", longint'(underrun), 1);
      checkOutput("ramp_sat", longint'(sat), 0);

      // Negative fractional slope shows floor rounding
      doReset();
      applyStimulus(1'b1, 1'b1, 10, -128, 4);
      for (int i = 0; i < 4; i++) begin
         idleCycles(1);
         checkOutput("negslope", longint'($signed(out_value)), (i == 0) ? 10 : (i == 3) ? 8 : 9);
      end
      idleCycles(2);

      // Back-to-back segments without a gap
      doReset();
      applyStimulus(1'b1, 1'b1, 0, 0, 2);
      applyStimulus(1'b1, 1'b1, 50, 0, 1);
      checkOutput("b2b_s0", longint'($signed(out_value)), 0);
      idleCycles(1);
      checkOutput("b2b_s1", longint'($signed(out_value)), 0);
      idleCycles(1);
      checkOutput("b2b_s2", longint'($signed(out_value)), 50);
      checkOutput("b2b_under_lo", longint'(underrun), 0);
      idleCycles(1);
      checkOutput("b2b_under_hi", longint'(underrun), 1);

      // Zero-length entry followed by a saturating ramp
      doReset();
      applyStimulus(1'b1, 1'b1, 7, 0, 0);
      applyStimulus(1'b1, 1'b1, 32760, 2560, 3);
      checkOutput("zl_not7", longint'(out_valid), 0);
      idleCycles(1);
      checkOutput("zl_first", longint'($signed(out_value)), 32760);
      idleCycles(1);
      checkOutput("sat_s1", longint'($signed(out_value)), 32767);
      checkOutput("sat_flag", longint'(sat), 1);
      idleCycles(1);
      checkOutput("sat_s2", longint'($signed(out_value)), 32767);
      idleCycles(2);

      // Backpressure: valid held high with long segments
      doReset();
      acceptCount = 0;
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, i * 10, 0, 100);
      checkOutput("bp_accepted5", acceptCount, 5);
      checkOutput("bp_ready_low", longint'(seg_ready), 0);
      for (int i = 0; i < 90; i++) applyStimulus(1'b1, 1'b1, 7, 0, 100);
      checkOutput("bp_accepted6", acceptCount, 6);

      // Reset in the middle of a run with segments queued
      doReset();
      applyStimulus(1'b1, 1'b1, 100, 256, 10);
      applyStimulus(1'b1, 1'b1, 1, 1, 5);
      applyStimulus(1'b1, 1'b1, 2, 2, 5);
      checkOutput("mid_sample2", longint'($signed(out_value)), 101);
      applyStimulus(1'b0, 1'b0, 0, 0, 0);
      checkOutput("mid_out", longint'($signed(out_value)), 0);
      checkOutput("mid_valid", longint'(out_valid), 0);
      checkOutput("mid_busy", longint'(busy), 0);
      checkOutput("mid_under", longint'(underrun), 0);
      applyStimulus(1'b1, 1'b1, -5, 0, 2);
      checkOutput("mid_relatency", longint'(out_valid), 0);
      idleCycles(1);
      checkOutput("mid_fresh", longint'($signed(out_value)), -5);
      idleCycles(3);

      // Random segment traffic, including zero lengths, clipping and resets
      doReset();
      for (int i = 0; i < 900; i++) begin
         int v, s, n;
         bit rstn;
         v = int'($signed(16'($urandom)));
         if ($urandom_range(0, 3) == 0) s = int'($signed(16'($urandom)));
         else s = $urandom_range(0, 1024) - 512;
         n = $urandom_range(0, 6);
         rstn = ($urandom_range(0, 99) != 0);
         applyStimulus(rstn, ($urandom_range(0, 2) == 0), v, s, n);
      end
      idleCycles(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/pwl_stim_gen.md
Name: pwl_stim_gen

Overview:
- Synthesizable piecewise-linear stimulus source that drives a fixed-point analog model input, such as a v_in port of a generated model, so the bench does not have to force a real-valued input.
- A host pushes segments through a valid/ready handshake. Each segment is (start value, slope, length in cycles).
- The block emits one fixed-point sample per clock, interpolating linearly within each segment.
- It sits between a bench or CPU stimulus source and the model's fixed-point input.

Parameters:
- WIDTH, 16: signed width of seg_value and out_value. The exponent is owned by the caller, matching the model input format.
- SLOPE_WIDTH, 16: signed width of seg_slope.
- SLOPE_FRAC, 8: number of fractional bits of seg_slope, in out_value LSBs per cycle.
- DUR_WIDTH, 16: width of seg_cycles.
- DEPTH, 4: segment FIFO depth, excluding the active segment. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- seg_valid  in  1  segment offered
- seg_ready  out  1  segment FIFO can accept
- seg_value  in  WIDTH  signed segment start value
- seg_slope  in  SLOPE_WIDTH  signed per-cycle increment, SLOPE_FRAC fractional bits
- seg_cycles  in  DUR_WIDTH  segment length in output cycles; 0 = discard
- out_value  out  WIDTH  signed registered stimulus sample
- out_valid  out  1  out_value meaningful
- busy  out  1  a segment is active or the FIFO is non-empty
- underrun  out  1  sticky: active segment ended with FIFO empty
- sat  out  1  sticky: out_value clipped

Behaviour:
- Reset: all state clears on a clk edge with rst_n=0, regardless of activity in progress.
  - Outputs: out_value=0, out_valid=0, busy=0, underrun=0, sat=0.
  - FIFO empties; the active segment and remaining count clear.
  - seg_ready=0 while rst_n=0.
- Handshake: a segment is accepted on an edge where seg_valid && seg_ready.
  - seg_ready = !fifo_full, with no same-cycle bypass when full.
  - seg_value/slope/cycles are captured into the FIFO at the accept edge.
- Zero-length segments (seg_cycles=0) are written to the FIFO. They are dropped at pop time, consuming no output cycle; the next entry is evaluated on the same edge.
  - Pop logic skips at most one zero-length entry per edge.
  - A zero-length head followed by an empty FIFO counts as an end-of-segment with an empty FIFO (underrun rule applies).
- State machine, IDLE / RUN:
  - IDLE -> RUN on an edge where the FIFO head is non-zero-length. That edge pops the head, sets acc = seg_value << SLOPE_FRAC, out_value=seg_value, remaining=seg_cycles-1, out_valid=1.
  - RUN, remaining>0: acc += sign-extended slope; remaining -= 1.
  - RUN, remaining=0, FIFO has a segment: load it on that edge exactly as from IDLE, with no gap cycle.
  - RUN, remaining=0, FIFO empty: go to IDLE, set underrun=1, hold out_value.
- First-sample latency: a segment accepted at edge t from an empty IDLE block appears on out_value after edge t+1.
- A segment of N cycles produces exactly N samples: v, v+s, ..., v+(N-1)s.
- Arithmetic:
  - acc is WIDTH+SLOPE_FRAC+2 bits signed.
  - out_value = acc arithmetically shifted right by SLOPE_FRAC (floor).
  - Saturation is to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. acc itself clamps to the saturated value << SLOPE_FRAC, so there is no wrap.
  - sat is set sticky on any clip.
- out_valid stays 1 from the first segment start until reset. In IDLE the last value is held.
- busy = RUN || !fifo_empty.
- Simultaneous push and pop on the same edge are both honoured, and the FIFO count is unchanged.
- underrun and sat clear only on reset.

Test Plan:
- Single ramp, SLOPE_FRAC=8: push (100, 256, 4) from reset.
  - Required: out_value 100, 101, 102, 103 on consecutive cycles, then holds 103.
  - Flags: out_valid=1 from the first sample; busy falls after 103; underrun=1 after 103; sat=0.
- Negative fractional slope: push (10, -128, 4).
  - Required: out_value 10, 9, 9, 8, showing floor rounding of 9.5 and 8.5.
- Back-to-back: push (0, 0, 2), then (50, 0, 1) before the first ends.
  - Required: out_value 0, 0, 50 with no gap.
  - underrun stays 0 until after 50, then becomes 1.
- Zero-length and saturation: push (7, 0, 0), then (32760, 2560, 3).
  - Required: 7 never appears; out_value 32760, 32767, 32767; sat=1.
- Backpressure: DEPTH=4, from IDLE hold seg_valid=1 with five segments of length 100.
  - Required: 5 segments accepted (1 active + 4 queued), then seg_ready=0 until the first segment finishes.
  - After that, exactly one more segment is accepted.
- Reset mid-run: assert rst_n=0 for one edge during sample 2 of (100, 256, 10) with 2 segments queued.
  - Required: out_value=0, out_valid=0, busy=0, flags clear, FIFO empty.
  - A fresh push afterward starts cleanly with 1-edge latency.
